// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers. Each channel produces a ~50% duty
// divided clock and a one-cycle wrap tick; divisor updates take effect only at a period boundary.
module clock_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 28,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic                clkold,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_wr,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [WIDTH-1:0]    div_val,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [WIDTH-1:0] DEF_DIV = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < WIDTH'(2)) ? WIDTH'(2) : v;
  endfunction

  logic             sel_ok;
  logic [WIDTH-1:0] wr_div;

  // Selects outside the populated channel range must never alias onto a real channel.
  assign sel_ok = (int'({1'b0, div_sel}) < CHANNELS);
  assign wr_div = clamp_div(div_val);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             hit;
    logic             wrap;

    assign hit  = div_wr && sel_ok && (div_sel == SEL_W'(i));
    assign wrap = (cnt_q >= act_q - WIDTH'(1));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      if (en[i]) begin
        clk_d  = (cnt_q < (act_q >> 1));
        tick_d = wrap;
        if (wrap) begin
          cnt_d = '0;
          // A write landing on the wrap edge bypasses the shadow and never raises pending.
          if (hit) begin
            act_d  = wr_div;
            shd_d  = wr_div;
            pend_d = 1'b0;
          end else if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          if (hit) begin
            shd_d  = wr_div;
            pend_d = 1'b1;
          end
        end
      end else begin
        // Idle channel: every edge is a boundary, so any pending divisor lands now.
        cnt_d = '0;
        if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
        if (hit) begin
          shd_d  = wr_div;
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clkold or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        act_q  <= DEF_DIV;
        shd_q  <= DEF_DIV;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: a per-cycle behavioural model plus
// directed waveform counts for each scenario.
module tb_clock_divider_bank;

  localparam int CH  = 4;
  localparam int W   = 28;
  localparam int SW  = 3;
  localparam int DEF = 1000;

  logic          clkold = 1'b0;
  logic          rst    = 1'b0;
  logic [CH-1:0] en     = '0;
  logic          div_wr = 1'b0;
  logic [SW-1:0] div_sel = '0;
  logic [W-1:0]  div_val = '0;
  logic [CH-1:0] clk_out, tick, pending;

  int checks = 0;
  int fails  = 0;

  clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW), .DEFAULT_DIV(DEF)) dut (
    .clkold (clkold),
    .rst    (rst),
    .en     (en),
    .div_wr (div_wr),
    .div_sel(div_sel),
    .div_val(div_val),
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  always #5 clkold = ~clkold;

  // Reference model: each channel is "position within current period" plus the
  // period length in force and an optional queued length.
  int            m_pos [CH];
  int            m_per [CH];
  int            m_next[CH];
  logic [CH-1:0] m_clk, m_tick, m_pend;

  function automatic int clampd(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  always @(posedge clkold or posedge rst) begin
    bit last;
    bit wr_here;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_pos[c] = 0; m_per[c] = DEF; m_next[c] = DEF;
      end
      m_clk = '0; m_tick = '0; m_pend = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        wr_here = div_wr && (int'(div_sel) == c);
        if (!en[c]) begin
          m_clk[c] = 1'b0; m_tick[c] = 1'b0; m_pos[c] = 0;
          if (m_pend[c]) begin m_per[c] = m_next[c]; m_pend[c] = 1'b0; end
          if (wr_here) begin m_next[c] = clampd(int'(div_val)); m_pend[c] = 1'b1; end
        end else begin
          last = (m_pos[c] + 1 == m_per[c]);
          m_clk[c]  = (m_pos[c] < m_per[c] / 2);
          m_tick[c] = last;
          if (last) begin
            m_pos[c] = 0;
            if (wr_here) begin
              m_per[c] = clampd(int'(div_val)); m_next[c] = m_per[c]; m_pend[c] = 1'b0;
            end else if (m_pend[c]) begin
              m_per[c] = m_next[c]; m_pend[c] = 1'b0;
            end
          end else begin
            m_pos[c] = m_pos[c] + 1;
            if (wr_here) begin m_next[c] = clampd(int'(div_val)); m_pend[c] = 1'b1; end
          end
        end
      end
    end
  end

  task automatic do_reset();
    en = '0; div_wr = 1'b0; div_sel = '0; div_val = '0;
    @(posedge clkold); #1 rst = 1'b1;
    @(posedge clkold); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clkold); #1 rst = 1'b1; en = '1;
    @(posedge clkold); #1;
    checks++; if (clk_out !== 4'h0) begin fails++; $display("FAIL reset_clk_out got=%h exp=0", clk_out); end
    checks++; if (tick !== 4'h0) begin fails++; $display("FAIL reset_tick got=%h exp=0", tick); end
    checks++; if (pending !== 4'h0) begin fails++; $display("FAIL reset_pending got=%h exp=0", pending); end
    rst = 1'b0; en = '0;
  endtask

  task automatic test_default();
    int highs, ticks, pends;
    highs = 0; ticks = 0; pends = 0;
    do_reset();
    en = '1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clkold); #1;
      checks++;
      if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
        fails++; $display("FAIL default_model edge=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {m_clk, m_tick, m_pend});
      end
      highs += $countones(clk_out); ticks += $countones(tick); pends += $countones(pending);
    end
    checks++; if (highs != 4000) begin fails++; $display("FAIL default_high_cycles got=%0d exp=4000", highs); end
    checks++; if (ticks != 8) begin fails++; $display("FAIL default_ticks got=%0d exp=8", ticks); end
    checks++; if (pends != 0) begin fails++; $display("FAIL default_pending got=%0d exp=0", pends); end
  endtask

  task automatic test_write_mid();
    int pend1, ticks1, highs1, last_tick;
    pend1 = 0; ticks1 = 0; highs1 = 0; last_tick = 0;
    do_reset();
    en = '1;
    for (int k = 1; k <= 1030; k++) begin
      div_wr = (k == 201); div_sel = 3'd1; div_val = W'(6);
      @(posedge clkold); #1;
      checks++;
      if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
        fails++; $display("FAIL write_mid_model edge=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {m_clk, m_tick, m_pend});
      end
      pend1 += int'(pending[1]);
      if (k == 1000) begin
        checks++; if (tick !== 4'hF) begin fails++; $display("FAIL write_mid_old_wrap got=%h exp=f", tick); end
      end
      if (k > 1000) begin
        ticks1 += int'(tick[1]); highs1 += int'(clk_out[1]);
        if (tick[1]) last_tick = k;
      end
    end
    div_wr = 1'b0;
    checks++; if (pend1 != 799) begin fails++; $display("FAIL write_mid_pending_cycles got=%0d exp=799", pend1); end
    checks++; if (ticks1 != 5) begin fails++; $display("FAIL write_mid_new_ticks got=%0d exp=5", ticks1); end
    checks++; if (highs1 != 15) begin fails++; $display("FAIL write_mid_new_highs got=%0d exp=15", highs1); end
    checks++; if (last_tick != 1030) begin fails++; $display("FAIL write_mid_last_tick got=%0d exp=1030", last_tick); end
  endtask

  task automatic test_clamp_odd();
    int t0, h0, t1, h1;
    t0 = 0; h0 = 0; t1 = 0; h1 = 0;
    do_reset();
    en = '1;
    for (int k = 1; k <= 1014; k++) begin
      div_wr = (k <= 3);
      div_sel = (k == 3) ? 3'd1 : 3'd0;
      div_val = (k == 1) ? W'(5) : (k == 2) ? W'(0) : W'(7);
      @(posedge clkold); #1;
      checks++;
      if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
        fails++; $display("FAIL clamp_model edge=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {m_clk, m_tick, m_pend});
      end
      if (k > 1000) begin
        t0 += int'(tick[0]); h0 += int'(clk_out[0]);
        t1 += int'(tick[1]); h1 += int'(clk_out[1]);
      end
    end
    div_wr = 1'b0;
    checks++; if (t0 != 7) begin fails++; $display("FAIL clamp_d2_ticks got=%0d exp=7", t0); end
    checks++; if (h0 != 7) begin fails++; $display("FAIL clamp_d2_highs got=%0d exp=7", h0); end
    checks++; if (t1 != 2) begin fails++; $display("FAIL odd_d7_ticks got=%0d exp=2", t1); end
    checks++; if (h1 != 6) begin fails++; $display("FAIL odd_d7_highs got=%0d exp=6", h1); end
  endtask

  task automatic test_coincident();
    int pends, t2, h2, t1;
    pends = 0; t2 = 0; h2 = 0; t1 = 0;
    do_reset();
    en = '1;
    for (int k = 1; k <= 1016; k++) begin
      div_wr  = (k == 10) || (k == 1000);
      div_sel = (k == 10) ? 3'd5 : 3'd2;
      div_val = (k == 10) ? W'(3) : W'(8);
      @(posedge clkold); #1;
      checks++;
      if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
        fails++; $display("FAIL coincident_model edge=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {m_clk, m_tick, m_pend});
      end
      pends += $countones(pending);
      if (k > 1000) begin
        t2 += int'(tick[2]); h2 += int'(clk_out[2]); t1 += int'(tick[1]);
      end
    end
    div_wr = 1'b0;
    checks++; if (pends != 0) begin fails++; $display("FAIL coincident_pending got=%0d exp=0", pends); end
    checks++; if (t2 != 2) begin fails++; $display("FAIL coincident_d8_ticks got=%0d exp=2", t2); end
    checks++; if (h2 != 8) begin fails++; $display("FAIL coincident_d8_highs got=%0d exp=8", h2); end
    checks++; if (t1 != 0) begin fails++; $display("FAIL bad_sel_ticks got=%0d exp=0", t1); end
  endtask

  task automatic test_disable();
    int off_act, h3, t3;
    off_act = 0; h3 = 0; t3 = 0;
    do_reset();
    en = '1;
    for (int k = 1; k <= 340; k++) begin
      en[3]  = !(k >= 301 && k <= 320);
      div_wr = (k == 305); div_sel = 3'd3; div_val = W'(10);
      @(posedge clkold); #1;
      checks++;
      if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
        fails++; $display("FAIL disable_model edge=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {m_clk, m_tick, m_pend});
      end
      if (k >= 301 && k <= 320) off_act += int'(clk_out[3]) + int'(tick[3]);
      if (k >= 321) begin h3 += int'(clk_out[3]); t3 += int'(tick[3]); end
      if (k == 305) begin
        checks++; if (pending[3] !== 1'b1) begin fails++; $display("FAIL disable_pending_set got=%b exp=1", pending[3]); end
      end
      if (k == 306) begin
        checks++; if (pending[3] !== 1'b0) begin fails++; $display("FAIL disable_pending_clear got=%b exp=0", pending[3]); end
      end
    end
    div_wr = 1'b0;
    checks++; if (off_act != 0) begin fails++; $display("FAIL disable_held_low got=%0d exp=0", off_act); end
    checks++; if (h3 != 10) begin fails++; $display("FAIL reenable_highs got=%0d exp=10", h3); end
    checks++; if (t3 != 2) begin fails++; $display("FAIL reenable_ticks got=%0d exp=2", t3); end
  endtask

  task automatic test_async_reset();
    int highs, ticks;
    highs = 0; ticks = 0;
    do_reset();
    en = '1;
    for (int k = 1; k <= 100; k++) begin
      div_wr = (k == 50); div_sel = 3'd0; div_val = W'(4);
      @(posedge clkold); #1;
    end
    div_wr = 1'b0;
    checks++; if ({clk_out, pending[0]} !== 5'b11111) begin fails++; $display("FAIL async_pre_state got=%h exp=1f", {clk_out, pending[0]}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({clk_out, tick, pending} !== 12'h000) begin fails++; $display("FAIL async_reset_outputs got=%h exp=000", {clk_out, tick, pending}); end
    #1 rst = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clkold); #1;
      checks++;
      if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
        fails++; $display("FAIL async_after_model edge=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {m_clk, m_tick, m_pend});
      end
      highs += $countones(clk_out); ticks += $countones(tick);
    end
    checks++; if (highs != 2000) begin fails++; $display("FAIL async_after_highs got=%0d exp=2000", highs); end
    checks++; if (ticks != 4) begin fails++; $display("FAIL async_after_ticks got=%0d exp=4", ticks); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 1; k <= 4000; k++) begin
      for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 9) != 0);
      div_wr  = ($urandom_range(0, 3) == 0);
      div_sel = SW'($urandom_range(0, 7));
      div_val = W'($urandom_range(0, 12));
      @(posedge clkold); #1;
      checks++;
      if ({clk_out, tick, pending} !== {m_clk, m_tick, m_pend}) begin
        fails++; $display("FAIL random_model edge=%0d got=%h exp=%h", k, {clk_out, tick, pending}, {m_clk, m_tick, m_pend});
      end
    end
    div_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_write_mid();
    test_clamp_odd();
    test_coincident();
    test_disable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock-enable/divided-clock generator, successor to the fixed single-divisor divider. Each of CHANNELS independent channels divides `clkold` by a runtime-programmable divisor, producing a ~50% duty square wave plus a one-cycle wrap tick. Divisor changes are double-buffered and applied only at a period boundary, so outputs never glitch or truncate a period. It sits between the board clock and the slow peripheral timebases (display scan, debounce, UART baud, LED blink).

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 28: counter and divisor width in bits.
- `SEL_W`, 2: width of `div_sel`; must satisfy 2^SEL_W >= CHANNELS.
- `DEFAULT_DIV`, 1000: divisor loaded into every channel at reset; values < 2 are clamped to 2.

- `clkold` in 1: sole clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in CHANNELS: per-channel run enable, bit i controls channel i.
- `div_wr` in 1: divisor write strobe, one write per asserted cycle.
- `div_sel` in SEL_W: target channel of the write.
- `div_val` in WIDTH: new divisor D; values 0 and 1 are clamped to 2.
- `clk_out` out CHANNELS: registered divided clock per channel.
- `tick` out CHANNELS: registered one-cycle pulse per completed period.
- `pending` out CHANNELS: 1 while a written divisor awaits its period boundary.

## Operation
- Per channel state: `cnt` (WIDTH), active divisor `act`, shadow divisor `shd`, `pending` flag.
- Reset: `cnt`=0, `act`=`shd`=clamp(DEFAULT_DIV), `pending`=0, `clk_out`=0, `tick`=0, all asynchronously.
- Enabled channel, each edge: wrap = (`cnt` >= `act`-1). If wrap: `cnt`<=0, else `cnt`<=`cnt`+1.
- `clk_out` <= (`cnt` < `act`>>1), evaluated on pre-edge `cnt`/`act`. Odd D: high floor(D/2), low ceil(D/2) cycles.
- `tick` <= wrap (enabled only). Period of both outputs is exactly `act` cycles.
- Write (`div_wr`=1, `div_sel` < CHANNELS): `shd`<=clamp(`div_val`), `pending`<=1. `div_sel` >= CHANNELS: ignored, no state change.
- Boundary apply: on a wrap edge with `pending`=1, `act`<=`shd`, `pending`<=0; the new period starts at `cnt`=0 with new D.
- Simultaneous write and wrap on same channel: written value applied directly at that wrap (`act`<=clamp(`div_val`)), `pending` stays 0.
- Repeated writes before boundary: last write wins; only one apply occurs.
- Disabled channel (`en[i]`=0), each edge: `cnt`<=0, `clk_out`<=0, `tick`<=0; if `pending`, `act`<=`shd` and `pending`<=0. Write while disabled is therefore applied on the following edge.
- Re-enable: channel restarts exactly as after reset (first edge drives `clk_out` high), using current `act`.
- Channels are fully independent; writes to one never disturb another's count.

## Timing
- Latency: `clk_out` and `tick` are registered, one cycle behind `cnt`.
- D=4 from reset, `en`=1: `clk_out` 0 until edge 1, then 1,1,0,0 repeating; `tick` high for the cycle after edges 4, 8, 12...
- Minimum D=2: `clk_out` toggles every edge, `tick` every second cycle.
- Divisor write at cycle t: `pending` visible at t+1; new period length begins at first wrap after t; the in-flight period finishes with old D.
- `rst` mid-operation: outputs and pending writes cleared immediately, no clock required.
- `cnt` never exceeds `act`-1 except transiently impossible; `>=` compare keeps wrap safe regardless.

## Test plan
- Reset, `en`=all 1, default D=1000: each `clk_out` high 500 / low 500 cycles, `tick` every 1000 cycles, `pending`=0.
- Write D=6 to ch1 mid-period at `cnt`=200: ch1 finishes 1000-cycle period, then 3 high/3 low, `pending` high from write+1 until that wrap; ch0/2/3 unaffected.
- Write D=5, then D=0 before boundary: clamps to 2, only D=2 applied; odd D=7 separately: 3 high/4 low, tick every 7.
- Write coincident with wrap edge on ch2 (D=8): next period is 8 cycles, `pending` never asserts; write to `div_sel`=5 with CHANNELS=4: no effect.
- Disable ch3 mid-period, write D=10, re-enable after 20 cycles: `clk_out`/`tick` held 0 while disabled, `pending` cleared one edge after write, restarts with 5 high/5 low.
- Assert `rst` asynchronously mid-period between edges: all outputs 0 immediately; after release behavior matches the first scenario.
